// File: rtl/imem_loader.sv
// Instruction-memory loader: unpacks a length-prefixed big-endian byte stream into 32-bit words,
// writes them from address 0 upward and holds the CPU in reset until the program is in place.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StWord,
    StWrite,
    StDone,
    StError
  } state_e;

  state_e                r_state;
  logic [15:0]           r_count;
  logic [ADDR_WIDTH-1:0] r_widx;
  logic [1:0]            r_bidx;
  logic [31:0]           r_shift;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;

  logic        w_accept;
  logic [15:0] w_len;
  logic        w_last;

  assign w_accept = in_valid && in_ready;
  assign w_len    = {r_count[15:8], in_data};
  assign w_last   = (32'(r_widx) == (32'(r_count) - 32'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StLenHi;
      r_count <= '0;
      r_widx  <= '0;
      r_bidx  <= '0;
      r_shift <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      unique case (r_state)
        StLenHi: begin
          if (w_accept) begin
            r_count[15:8] <= in_data;
            r_state       <= StLenLo;
          end
        end
        StLenLo: begin
          if (w_accept) begin
            r_count[7:0] <= in_data;
            r_widx       <= '0;
            r_bidx       <= '0;
            if (w_len == 16'd0) begin
              r_state <= StDone;
            end else if (32'(w_len) > Depth) begin
              r_state <= StError;
            end else begin
              r_state <= StWord;
            end
          end
        end
        StWord: begin
          if (w_accept) begin
            r_shift <= {r_shift[23:0], in_data};
            r_bidx  <= r_bidx + 2'd1;
            // Latch address and word here so both hold steady after the write cycle.
            if (r_bidx == 2'd3) begin
              r_addr  <= r_widx;
              r_wdata <= {r_shift[23:0], in_data};
              r_state <= StWrite;
            end
          end
        end
        StWrite: begin
          if (w_last) begin
            r_state <= StDone;
          end else begin
            r_widx  <= r_widx + 1'b1;
            r_bidx  <= '0;
            r_state <= StWord;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign in_ready   = (r_state == StLenHi) || (r_state == StLenLo) || (r_state == StWord);
  assign imem_we    = (r_state == StWrite);
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_reset  = (r_state != StDone);
  assign done       = (r_state == StDone);
  assign error      = (r_state == StError);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: normal, gapped, empty, oversize, full-depth
// and reset-mid-load streams, with a write log captured on the falling edge.
module tb_imem_loader;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  imem_loader #(.ADDR_WIDTH(AW)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Log every write; in_ready must be low whenever the write strobe is up.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      log_addr.push_back(32'(imem_addr));
      log_data.push_back(imem_wdata);
      check_eq("ready_low_in_write", 32'(in_ready), 32'd0);
    end
  end

  task automatic do_reset(input logic hold_valid);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = hold_valid;
    in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check_eq("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic gaps);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_we"}, 32'(imem_we), 32'd0);
    check_eq({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check_eq({tag, "_wdata"}, imem_wdata, 32'd0);
    check_eq({tag, "_cpurst"}, 32'(cpu_reset), 32'd1);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_error"}, 32'(error), 32'd0);
  endtask

  logic [31:0] prog[3];

  task automatic run_prog3(input string tag, input logic gaps);
    do_reset(1'b0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 3; i++) send_word(prog[i], gaps);
    // Returns at the negedge inside the final write cycle.
    check_eq({tag, "_last_we"}, 32'(imem_we), 32'd1);
    check_eq({tag, "_done_pre"}, 32'(done), 32'd0);
    @(negedge clk);
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
    check_eq({tag, "_nwrites"}, 32'(log_addr.size()), 32'd3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      check_eq({tag, "_addr"}, log_addr[i], 32'(i));
      check_eq({tag, "_data"}, log_data[i], prog[i]);
    end
    check_eq({tag, "_addr_hold"}, 32'(imem_addr), 32'd2);
    check_eq({tag, "_wdata_hold"}, imem_wdata, 32'h01095020);
  endtask

  initial begin
    logic [31:0] w;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    prog[0]  = 32'h20080005;
    prog[1]  = 32'h20090007;
    prog[2]  = 32'h01095020;

    do_reset(1'b0);
    check_reset_outputs("rst");

    run_prog3("p3", 1'b0);
    run_prog3("p3gap", 1'b1);

    // Empty program, valid held high through reset: header taken on the two edges after release.
    do_reset(1'b1);
    @(negedge clk);
    check_eq("n0_done_early", 32'(done), 32'd0);
    @(negedge clk);
    check_eq("n0_done", 32'(done), 32'd1);
    check_eq("n0_cpurst", 32'(cpu_reset), 32'd0);
    check_eq("n0_ready", 32'(in_ready), 32'd0);
    in_data = 8'hAA;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    check_eq("n0_nwrites", 32'(log_addr.size()), 32'd0);
    check_eq("n0_done_hold", 32'(done), 32'd1);

    // Oversize header.
    do_reset(1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check_eq("big_error", 32'(error), 32'd1);
    check_eq("big_cpurst", 32'(cpu_reset), 32'd1);
    check_eq("big_ready", 32'(in_ready), 32'd0);
    check_eq("big_done", 32'(done), 32'd0);
    in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    check_eq("big_nwrites", 32'(log_addr.size()), 32'd0);

    // Full-depth load.
    do_reset(1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3};
      send_word(w, 1'b0);
    end
    @(negedge clk);
    check_eq("full_done", 32'(done), 32'd1);
    check_eq("full_nwrites", 32'(log_addr.size()), 32'd256);
    for (int i = 0; i < 256 && i < log_addr.size(); i++) begin
      w = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3};
      check_eq("full_addr", log_addr[i], 32'(i));
      check_eq("full_data", log_data[i], w);
    end

    // Reset mid-way through word 1, then a fresh single-word load.
    do_reset(1'b0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_word(prog[0], 1'b0);
    send_byte(8'h20, 0);
    send_byte(8'h09, 0);
    do_reset(1'b0);
    check_reset_outputs("midrst");
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check_eq("one_done", 32'(done), 32'd1);
    check_eq("one_nwrites", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() > 0) begin
      check_eq("one_addr", log_addr[0], 32'd0);
      check_eq("one_data", log_data[0], 32'hDEADBEEF);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
